tl45_alu: RTL and testbench

Execute stage of the tl45 pipeline, directly downstream of register read. Consumes the opcode, destination register and resolved operand values, and computes single-cycle ALU results. Registers the result into the ALU stage buffer for the memory stage. Drives both operand-forwarding buses back to register read. An optional iterative multiplier stalls the pipeline for the duration of a MUL.

---
 rtl/tl45_alu_pkg.sv | 24 ++
 rtl/tl45_alu_if.sv | 31 +++
 rtl/tl45_alu_mul_iter.sv | 62 ++++++
 rtl/tl45_alu.sv | 120 ++++++++++++
 tb/tb_tl45_alu.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tl45_alu_pkg.sv
// Shared tl45 definitions: opcodes, flag bit positions and multiplier latency.
package tl45_alu_pkg;

    typedef enum logic [4:0] {
        OP_NOP = 5'd0,
        OP_ADD = 5'd1,
        OP_SUB = 5'd2,
        OP_AND = 5'd3,
        OP_OR  = 5'd4,
        OP_XOR = 5'd5,
        OP_SHL = 5'd6,
        OP_SHR = 5'd7,
        OP_MUL = 5'd8
    } opcode_e;

    // o_flags layout is {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int MUL_CYCLES = 32;

endpackage

// File: rtl/tl45_alu_if.sv
// Register-read <-> execute stage bus: operands, stall/flush and both forwarding paths.
interface tl45_alu_if;
    logic        i_pipe_stall;
    logic        o_pipe_stall;
    logic        i_pipe_flush;
    logic        o_pipe_flush;
    logic [4:0]  i_opcode;
    logic [3:0]  i_dr;
    logic [31:0] i_sr1_val;
    logic [31:0] i_sr2_val;
    logic [3:0]  o_of1_reg;
    logic [31:0] o_of1_data;
    logic [3:0]  o_of2_reg;
    logic [31:0] o_of2_data;
    logic [4:0]  o_opcode;
    logic [3:0]  o_dr;
    logic [31:0] o_value;
    logic [3:0]  o_flags;

    modport master (
        output i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1_val, i_sr2_val,
        input  o_pipe_stall, o_pipe_flush, o_of1_reg, o_of1_data, o_of2_reg, o_of2_data,
               o_opcode, o_dr, o_value, o_flags
    );

    modport slave (
        input  i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1_val, i_sr2_val,
        output o_pipe_stall, o_pipe_flush, o_of1_reg, o_of1_data, o_of2_reg, o_of2_data,
               o_opcode, o_dr, o_value, o_flags
    );
endinterface

// File: rtl/tl45_alu_mul_iter.sv
// Iterative shift-add multiplier, one product bit per cycle; low 32 bits kept.
module tl45_mul_iter
    import tl45_alu_pkg::*;
#(
    parameter int CYCLES = MUL_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        start,
    input  logic        ack,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    localparam int CW = $clog2(CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state;
    logic [CW-1:0]   count;
    logic [31:0]     mcand, mplier, acc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= S_IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state  <= S_BUSY;
                    count  <= '0;
                    mcand  <= a;
                    mplier <= b;
                    acc    <= '0;
                end
                S_BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(CYCLES - 1)) state <= S_DONE;
                end
                S_DONE: if (ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state == S_BUSY);
    assign done    = (state == S_DONE);
    assign product = acc;

endmodule

// File: rtl/tl45_alu.sv
// tl45 execute stage: single-cycle ALU, stage buffer, flags and forwarding.
// Optional iterative multiplier enabled by defining TL45_ALU_MUL_EN.
module tl45_alu
    import tl45_alu_pkg::*;
(
    input logic       i_clk,
    input logic       i_reset_n,
    tl45_alu_if.slave bus
);
    logic [31:0] a, b, res;
    logic [32:0] sum, diff;
    logic [3:0]  of1_reg, flags_next;
    logic        flag_we, v_flag, c_flag, mul_stall;

    assign a    = bus.i_sr1_val;
    assign b    = bus.i_sr2_val;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef TL45_ALU_MUL_EN
    logic        mul_start, mul_busy, mul_done;
    logic [31:0] mul_product;

    assign mul_start = (bus.i_opcode == OP_MUL) && !bus.i_pipe_flush && !mul_busy && !mul_done;
    assign mul_stall = mul_start || mul_busy;

    tl45_mul_iter #(.CYCLES(MUL_CYCLES)) u_mul (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .start     (mul_start),
        .ack       (!bus.i_pipe_stall),
        .abort     (bus.i_pipe_flush),
        .a         (a),
        .b         (b),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );
`else
    assign mul_stall = 1'b0;
`endif

    always_comb begin
        res     = '0;
        of1_reg = bus.i_dr;
        flag_we = 1'b0;
        v_flag  = 1'b0;
        c_flag  = 1'b0;
        case (bus.i_opcode)
            OP_ADD: begin
                res     = sum[31:0];
                c_flag  = sum[32];
                v_flag  = (a[31] == b[31]) && (sum[31] != a[31]);
                flag_we = 1'b1;
            end
            OP_SUB: begin
                res     = diff[31:0];
                c_flag  = diff[32];
                v_flag  = (a[31] != b[31]) && (diff[31] != a[31]);
                flag_we = 1'b1;
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: res = a << b[4:0];
            OP_SHR: res = a >> b[4:0];
            OP_MUL: begin
`ifdef TL45_ALU_MUL_EN
                // product only becomes visible once the multiplier reaches DONE
                res     = mul_done ? mul_product : '0;
                of1_reg = mul_done ? bus.i_dr : '0;
`else
                of1_reg = '0;
`endif
            end
            default: of1_reg = '0;
        endcase
    end

    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_V] = v_flag;
        flags_next[FLAG_C] = c_flag;
        flags_next[FLAG_N] = res[31];
        flags_next[FLAG_Z] = (res == '0);
    end

    assign bus.o_pipe_stall = bus.i_pipe_stall || mul_stall;
    assign bus.o_pipe_flush = bus.i_pipe_flush;
    assign bus.o_of1_reg    = of1_reg;
    assign bus.o_of1_data   = res;
    assign bus.o_of2_reg    = bus.o_dr;
    assign bus.o_of2_data   = bus.o_value;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_opcode <= '0;
            bus.o_dr     <= '0;
            bus.o_value  <= '0;
            bus.o_flags  <= '0;
        end else if (bus.i_pipe_flush) begin
            bus.o_opcode <= '0;
            bus.o_dr     <= '0;
            bus.o_value  <= '0;
        end else if (!bus.i_pipe_stall) begin
            // while the multiplier holds register read, feed bubbles so nothing is issued twice
            if (mul_stall) begin
                bus.o_opcode <= '0;
                bus.o_dr     <= '0;
                bus.o_value  <= '0;
            end else begin
                bus.o_opcode <= bus.i_opcode;
                bus.o_dr     <= of1_reg;
                bus.o_value  <= res;
            end
            if (flag_we) bus.o_flags <= flags_next;
        end
    end

endmodule

// File: tb/tb_tl45_alu.sv
// Directed bench for tl45_alu: vector table for single-cycle ops plus stall/flush/reset/MUL sequences.
module tb_tl45_alu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tl45_alu_if bus ();

    tl45_alu dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  dr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] xval;
        logic [3:0]  xflags;
    } vec_t;

    vec_t vecs[13];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [3:0] dr,
                         input logic [31:0] a, input logic [31:0] b);
        bus.i_opcode  = op;
        bus.i_dr      = dr;
        bus.i_sr1_val = a;
        bus.i_sr2_val = b;
    endtask

`ifdef TL45_ALU_MUL_EN
    // Issues 7*6 -> r5; optionally holds a downstream stall for 3 cycles in DONE.
    task automatic run_mul(input bit stall_done);
        int          cnt;
        logic [3:0]  fl;
        fl  = bus.o_flags;
        cnt = 0;
        drive(5'd8, 4'd5, 32'd7, 32'd6);
        for (int k = 0; k < 100; k++) begin
            #1;
            if (!bus.o_pipe_stall) break;
            cnt++;
            if (k == 0) chk("mul_of1_idle", {28'd0, bus.o_of1_reg}, 32'd0);
            edge1();
            chk("mul_bubble", {27'd0, bus.o_opcode}, 32'd0);
        end
        chk("mul_stall_cycles", cnt, 33);
        chk("mul_of1_reg_done", {28'd0, bus.o_of1_reg}, 32'd5);
        chk("mul_of1_data_done", bus.o_of1_data, 32'd42);
        if (stall_done) begin
            bus.i_pipe_stall = 1'b1;
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("mul_done_stall_out", {31'd0, bus.o_pipe_stall}, 32'd1);
                edge1();
                chk("mul_done_hold_val", bus.o_value, 32'd0);
                chk("mul_done_hold_of1", bus.o_of1_data, 32'd42);
            end
            bus.i_pipe_stall = 1'b0;
            #1;
        end
        edge1();
        chk("mul_value", bus.o_value, 32'd42);
        chk("mul_dr", {28'd0, bus.o_dr}, 32'd5);
        chk("mul_opcode", {27'd0, bus.o_opcode}, 32'd8);
        chk("mul_flags", {28'd0, bus.o_flags}, {28'd0, fl});
        drive(5'd0, 4'd0, 32'd0, 32'd0);
        #1;
        chk("mul_idle_stall", {31'd0, bus.o_pipe_stall}, 32'd0);
        edge1();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op    dr     a             b             value         {V,C,N,Z}
        vecs[0]  = '{5'd1, 4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'h5};
        vecs[1]  = '{5'd2, 4'd4,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'h8};
        vecs[2]  = '{5'd3, 4'd1,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'h8};
        vecs[3]  = '{5'd4, 4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 4'h8};
        vecs[4]  = '{5'd5, 4'd6,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'h8};
        vecs[5]  = '{5'd6, 4'd7,  32'h00000001, 32'h00000024, 32'h00000010, 4'h8};
        vecs[6]  = '{5'd7, 4'd8,  32'h80000000, 32'h0000001F, 32'h00000001, 4'h8};
        vecs[7]  = '{5'd6, 4'd9,  32'h12345678, 32'h00000020, 32'h12345678, 4'h8};
        vecs[8]  = '{5'd1, 4'd10, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'hA};
        vecs[9]  = '{5'd2, 4'd11, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'h6};
        vecs[10] = '{5'd2, 4'd12, 32'h00000009, 32'h00000009, 32'h00000000, 4'h1};
        vecs[11] = '{5'd1, 4'd13, 32'h80000000, 32'h80000000, 32'h00000000, 4'hD};
        vecs[12] = '{5'd5, 4'd14, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4'hD};

        rst_n = 1'b0;
        bus.i_pipe_stall = 1'b0;
        bus.i_pipe_flush = 1'b0;
        drive(5'd0, 4'd0, 32'd0, 32'd0);
        edge1();
        edge1();
        chk("rst_value", bus.o_value, 32'd0);
        chk("rst_opcode", {27'd0, bus.o_opcode}, 32'd0);
        chk("rst_flags", {28'd0, bus.o_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edge1();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op, vecs[i].dr, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d_of1_reg", i), {28'd0, bus.o_of1_reg}, {28'd0, vecs[i].dr});
            chk($sformatf("v%0d_of1_data", i), bus.o_of1_data, vecs[i].xval);
            chk($sformatf("v%0d_stall", i), {31'd0, bus.o_pipe_stall}, 32'd0);
            edge1();
            chk($sformatf("v%0d_opcode", i), {27'd0, bus.o_opcode}, {27'd0, vecs[i].op});
            chk($sformatf("v%0d_dr", i), {28'd0, bus.o_dr}, {28'd0, vecs[i].dr});
            chk($sformatf("v%0d_value", i), bus.o_value, vecs[i].xval);
            chk($sformatf("v%0d_of2_reg", i), {28'd0, bus.o_of2_reg}, {28'd0, vecs[i].dr});
            chk($sformatf("v%0d_of2_data", i), bus.o_of2_data, vecs[i].xval);
            chk($sformatf("v%0d_flags", i), {28'd0, bus.o_flags}, {28'd0, vecs[i].xflags});
        end

        // downstream stall holds buffer and flags
        bus.i_pipe_stall = 1'b1;
        drive(5'd1, 4'd2, 32'd1, 32'd1);
        #1;
        chk("dstall_out", {31'd0, bus.o_pipe_stall}, 32'd1);
        edge1();
        chk("dstall_value", bus.o_value, 32'hFFFFFFFF);
        chk("dstall_dr", {28'd0, bus.o_dr}, 32'd14);
        chk("dstall_flags", {28'd0, bus.o_flags}, 32'hD);
        bus.i_pipe_stall = 1'b0;
        edge1();
        chk("unstall_value", bus.o_value, 32'd2);
        chk("unstall_flags", {28'd0, bus.o_flags}, 32'h0);

        // flush clears the buffer
        bus.i_pipe_flush = 1'b1;
        drive(5'd3, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        chk("flush_passthru", {31'd0, bus.o_pipe_flush}, 32'd1);
        edge1();
        chk("flush_value", bus.o_value, 32'd0);
        chk("flush_dr", {28'd0, bus.o_dr}, 32'd0);
        chk("flush_opcode", {27'd0, bus.o_opcode}, 32'd0);
        bus.i_pipe_flush = 1'b0;

        // async reset without a clock edge
        drive(5'd2, 4'd4, 32'd5, 32'd7);
        edge1();
        chk("pre_rst_value", bus.o_value, 32'hFFFFFFFE);
        rst_n = 1'b0;
        #2;
        chk("arst_value", bus.o_value, 32'd0);
        chk("arst_dr", {28'd0, bus.o_dr}, 32'd0);
        chk("arst_opcode", {27'd0, bus.o_opcode}, 32'd0);
        chk("arst_flags", {28'd0, bus.o_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd0, 4'd0, 32'd0, 32'd0);
        edge1();

`ifdef TL45_ALU_MUL_EN
        run_mul(1'b0);
        run_mul(1'b1);

        // flush mid-BUSY
        drive(5'd8, 4'd5, 32'd7, 32'd6);
        for (int k = 0; k < 10; k++) edge1();
        chk("mflush_busy", {31'd0, bus.o_pipe_stall}, 32'd1);
        bus.i_pipe_flush = 1'b1;
        drive(5'd0, 4'd0, 32'd0, 32'd0);
        edge1();
        bus.i_pipe_flush = 1'b0;
        #1;
        chk("mflush_value", bus.o_value, 32'd0);
        chk("mflush_stall", {31'd0, bus.o_pipe_stall}, 32'd0);
        edge1();
        chk("mflush_stall2", {31'd0, bus.o_pipe_stall}, 32'd0);

        // reset mid-BUSY, with flags set beforehand
        drive(5'd2, 4'd4, 32'd5, 32'd7);
        edge1();
        drive(5'd8, 4'd5, 32'd7, 32'd6);
        for (int k = 0; k < 10; k++) edge1();
        chk("mrst_flags_pre", {28'd0, bus.o_flags}, 32'h6);
        drive(5'd0, 4'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #2;
        chk("mrst_flags", {28'd0, bus.o_flags}, 32'd0);
        chk("mrst_value", bus.o_value, 32'd0);
        chk("mrst_stall", {31'd0, bus.o_pipe_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edge1();
        run_mul(1'b0);
`else
        // without the multiplier, MUL is a non-stalling pass of opcode 8
        drive(5'd8, 4'd5, 32'd7, 32'd6);
        #1;
        chk("nomul_stall", {31'd0, bus.o_pipe_stall}, 32'd0);
        chk("nomul_of1_reg", {28'd0, bus.o_of1_reg}, 32'd0);
        edge1();
        chk("nomul_opcode", {27'd0, bus.o_opcode}, 32'd8);
        chk("nomul_dr", {28'd0, bus.o_dr}, 32'd0);
        chk("nomul_value", bus.o_value, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
